// File: rtl/clock_time_core_if.sv
// rtl/clock_time_core_if.sv - button inputs and BCD display outputs of the clock core
interface clock_time_core_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic       sec_pulse;
  logic [1:0] set_mode;

  modport master (
    output btn_mode, btn_inc,
    input  dig0, dig1, dig2, dig3, sec_pulse, set_mode
  );

  modport slave (
    input  btn_mode, btn_inc,
    output dig0, dig1, dig2, dig3, sec_pulse, set_mode
  );
endinterface

// File: rtl/clock_time_core.sv
// rtl/clock_time_core.sv - 24h BCD clock with hour/minute set FSM feeding the 7-seg decoder
// Optional button counter filter enabled by DEBOUNCE_EN.
module clock_time_core #(
  parameter int unsigned TICKS_PER_SEC = 100000000,
  parameter int unsigned DEB_CYCLES    = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  clock_time_core_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  mode_e          mode_q;
  logic           sec_pulse_q;
  logic [PW-1:0]  presc_q, presc_d;
  logic [7:0]     sec_q, sec_d;
  logic [7:0]     min_q, min_d;
  logic [7:0]     hr_q, hr_d;

  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0] btn_raw;
  logic [1:0] sync1_q, sync2_q, edge_q;
  logic [1:0] level;
  logic [1:0] press;
  logic       mode_ev, inc_ev;

  assign btn_raw = {bus.btn_inc, bus.btn_mode};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      edge_q  <= level;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    filt_q;
  logic [DW-1:0] deb_cnt_q [2];

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        filt_q[i]    <= 1'b0;
        deb_cnt_q[i] <= '0;
      end else if (sync2_q[i] == filt_q[i]) begin
        deb_cnt_q[i] <= '0;
      end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
        filt_q[i]    <= sync2_q[i];
        deb_cnt_q[i] <= '0;
      end else begin
        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
      end
    end
  end

  assign level = filt_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEB_CYCLES;
  assign level      = sync2_q;
`endif

  assign press   = level & ~edge_q;
  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  function automatic logic [7:0] inc_mod60(input logic [7:0] v);
    if (v[3:0] < 4'd9)
      return {v[7:4], v[3:0] + 4'd1};
    else if (v[7:4] < 4'd5)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return 8'h00;
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v[7:4] >= 4'd2 && v[3:0] >= 4'd3)
      return 8'h00;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic sec_wrap;
  assign sec_wrap = (mode_q == RUN) && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = '0;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    unique case (mode_q)
      RUN: begin
        presc_d = sec_wrap ? '0 : presc_q + 1'b1;
        if (sec_wrap) begin
          sec_d = inc_mod60(sec_q);
          if (sec_q == 8'h59) begin
            min_d = inc_mod60(min_q);
            if (min_q == 8'h59)
              hr_d = inc_hour(hr_q);
          end
        end
      end
      SET_HOUR: begin
        if (inc_ev && !mode_ev)
          hr_d = inc_hour(hr_q);
      end
      SET_MIN: begin
        // Returning to RUN restarts the current second from zero.
        if (mode_ev)
          sec_d = 8'h00;
        else if (inc_ev)
          min_d = inc_mod60(min_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      sec_q   <= 8'h00;
      min_q   <= 8'h00;
      hr_q    <= 8'h00;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= RUN;
      sec_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= sec_wrap;
      unique case (mode_q)
        RUN:      if (mode_ev) mode_q <= SET_HOUR;
        SET_HOUR: if (mode_ev) mode_q <= SET_MIN;
        SET_MIN:  if (mode_ev) mode_q <= RUN;
        default:  mode_q <= RUN;
      endcase
    end
  end

  assign bus.dig0      = min_q[3:0];
  assign bus.dig1      = min_q[7:4];
  assign bus.dig2      = hr_q[3:0];
  assign bus.dig3      = hr_q[7:4];
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.set_mode  = mode_q;

endmodule

// File: tb/tb_clock_time_core.sv
// tb/tb_clock_time_core.sv - directed self-checking bench for clock_time_core
module tb_clock_time_core;
  localparam int TICKS = 4;
  localparam int DEB   = 8;
`ifdef DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   pulse_cnt = 0;
  int   p0;
  int   p1;

  clock_time_core_if bus_if ();

  clock_time_core #(
    .TICKS_PER_SEC(TICKS),
    .DEB_CYCLES   (DEB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.sec_pulse === 1'b1) pulse_cnt++;

  logic [15:0] hhmm;
  assign hhmm = {bus_if.dig3, bus_if.dig2, bus_if.dig1, bus_if.dig0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Idle long enough to clear the button path, press, release right after the action edge.
  task automatic press(input bit inc);
    step(LAT);
    if (inc) bus_if.btn_inc = 1'b1;
    else     bus_if.btn_mode = 1'b1;
    step(LAT);
    bus_if.btn_inc  = 1'b0;
    bus_if.btn_mode = 1'b0;
  endtask

  task automatic presses(input bit inc, input int n);
    for (int i = 0; i < n; i++) press(inc);
  endtask

  initial begin
    #10000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    reset = 1'b1;
    step(2);
    chk("rst_digits", hhmm, 16'h0000);
    chk("rst_mode", bus_if.set_mode, 2'b00);
    chk("rst_pulse", bus_if.sec_pulse, 1'b0);
    reset = 1'b0;

    bus_if.btn_mode = 1'b1;
    step(LAT - 1);
    chk("mode_lat_early", bus_if.set_mode, 2'b00);
    step(1);
    chk("mode_lat", bus_if.set_mode, 2'b01);
    bus_if.btn_mode = 1'b0;

    p0 = pulse_cnt;
    presses(1'b1, 25);
    chk("hour_mod24", hhmm, 16'h0100);
    chk("set_no_pulse", pulse_cnt - p0, 0);
    chk("set_pulse_low", bus_if.sec_pulse, 1'b0);
    presses(1'b1, 22);
    chk("hour_23", hhmm, 16'h2300);
    press(1'b0);
    chk("mode_setmin", bus_if.set_mode, 2'b10);
    presses(1'b1, 59);
    chk("min_59", hhmm, 16'h2359);
    press(1'b1);
    chk("min_wrap_no_carry", hhmm, 16'h2300);
    presses(1'b1, 59);
    press(1'b0);
    chk("mode_run", bus_if.set_mode, 2'b00);
    p1 = pulse_cnt;
    step(3);
    chk("exit_no_early_tick", bus_if.sec_pulse, 1'b0);
    step(1);
    chk("exit_first_tick", bus_if.sec_pulse, 1'b1);
    step(232);
    chk("at_235959", hhmm, 16'h2359);
    step(3);
    chk("pre_midnight", hhmm, 16'h2359);
    step(1);
    chk("midnight", hhmm, 16'h0000);
    chk("midnight_pulse", bus_if.sec_pulse, 1'b1);
    step(236);
    chk("min_not_yet", hhmm, 16'h0000);
    step(4);
    chk("minute_carry", hhmm, 16'h0001);
    step(1);
    chk("pulse_count", pulse_cnt - p1, 120);

    bus_if.btn_mode = 1'b1;
    bus_if.btn_inc  = 1'b1;
    step(LAT);
    chk("simul_mode_wins", bus_if.set_mode, 2'b01);
    chk("simul_inc_dropped", hhmm, 16'h0001);
    bus_if.btn_mode = 1'b0;
    bus_if.btn_inc  = 1'b0;
    step(LAT);
    bus_if.btn_inc = 1'b1;
    step(50);
    bus_if.btn_inc = 1'b0;
    step(LAT);
    chk("hold_one_event", hhmm, 16'h0101);
    press(1'b0);
    press(1'b0);
    chk("back_to_run", bus_if.set_mode, 2'b00);
    press(1'b1);
    chk("run_inc_ignored", hhmm, 16'h0101);

    press(1'b0);
    presses(1'b1, 11);
    press(1'b0);
    presses(1'b1, 33);
    press(1'b0);
    step(224);
    chk("at_1234", hhmm, 16'h1234);
    step(3);
    reset = 1'b1;
    step(1);
    chk("midrst_digits", hhmm, 16'h0000);
    chk("midrst_mode", bus_if.set_mode, 2'b00);
    chk("midrst_pulse", bus_if.sec_pulse, 1'b0);
    reset = 1'b0;
    step(3);
    chk("post_rst_no_tick", bus_if.sec_pulse, 1'b0);
    step(1);
    chk("post_rst_tick", bus_if.sec_pulse, 1'b1);

`ifdef DEBOUNCE_EN
    bus_if.btn_mode = 1'b1;
    step(5);
    bus_if.btn_mode = 1'b0;
    step(20);
    chk("deb_glitch", bus_if.set_mode, 2'b00);
    bus_if.btn_mode = 1'b1;
    step(LAT - 1);
    chk("deb_lat_early", bus_if.set_mode, 2'b00);
    step(1);
    chk("deb_lat", bus_if.set_mode, 2'b01);
    bus_if.btn_mode = 1'b0;
    step(LAT);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
